// File: rtl/clock_pattern_gen_pkg.sv
// Shared types and constants for the clock pattern generator and its gate synchroniser.
package clock_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 16;

  // A programmed phase length of 0 is promoted to this value.
  localparam int MIN_LEN = 1;

endpackage

// File: rtl/clock_pattern_gate_sync.sv
// Pending-gate register; issues the gate only when no rising edge of the generated clock follows.
module clock_pattern_gate_sync
  import clock_pattern_gen_pkg::*;
#(
  parameter logic INIT_GATE = 1'b1
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  state_t state,
  input  logic   cnt_zero,
  input  logic   gate_en,
  input  logic   gate_val,
  output logic   gate_pend,
  output logic   cond_val,
  output logic   cond_val_en
);

  logic pend_reg, pend_next;
  logic val_reg, val_next;
  logic cond_reg, cond_next;
  logic cond_en_reg, cond_en_next;
  logic safe;
  logic issue;

  // The last LOW cycle is excluded: the next edge is a rising clock edge.
  assign safe  = (state == ST_IDLE) || ((state == ST_LOW) && !cnt_zero);
  assign issue = pend_reg && safe;

  always_comb begin
    pend_next    = gate_en | (pend_reg & ~issue);
    val_next     = gate_en ? gate_val : val_reg;
    cond_next    = issue ? val_reg : cond_reg;
    cond_en_next = issue;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_reg    <= 1'b0;
      val_reg     <= INIT_GATE;
      cond_reg    <= INIT_GATE;
      cond_en_reg <= 1'b0;
    end else begin
      pend_reg    <= pend_next;
      val_reg     <= val_next;
      cond_reg    <= cond_next;
      cond_en_reg <= cond_en_next;
    end
  end

  assign gate_pend   = pend_reg;
  assign cond_val    = cond_reg;
  assign cond_val_en = cond_en_reg;

endmodule

// File: rtl/clock_pattern_gen.sv
// Programmable high/low clock pattern driver for the gated-clock primitive.
// Optional burst mode (BURST_LEN/EDGES ports) is enabled by CLOCK_PATTERN_GEN_BURST_EN.
module clock_pattern_gen
  import clock_pattern_gen_pkg::*;
#(
  parameter int   CNT_W     = CNT_W_DEF,
  parameter logic INIT_VAL  = 1'b0,
  parameter logic INIT_GATE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_EN,
  input  logic [CNT_W-1:0] CFG_HI,
  input  logic [CNT_W-1:0] CFG_LO,
  output logic             CFG_RDY,
  input  logic             START,
  input  logic             STOP,
  input  logic             GATE_EN,
  input  logic             GATE_VAL,
  output logic             GATE_PEND,
  output logic             CLK_VAL,
  output logic             CLK_VAL_EN,
  output logic             COND_VAL,
  output logic             COND_VAL_EN,
`ifdef CLOCK_PATTERN_GEN_BURST_EN
  input  logic [CNT_W-1:0] BURST_LEN,
  output logic [CNT_W-1:0] EDGES,
`endif
  output logic             RUNNING
);

  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(MIN_LEN);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_len_reg, hi_len_next;
  logic [CNT_W-1:0] lo_len_reg, lo_len_next;
  logic [CNT_W-1:0] pend_hi_reg, pend_hi_next;
  logic [CNT_W-1:0] pend_lo_reg, pend_lo_next;
  logic             cfg_rdy_reg, cfg_rdy_next;
  logic             stop_reg, stop_next;
  logic             clk_val_reg, clk_val_next;
  logic             clk_en_reg, clk_en_next;
  logic             running_reg, running_next;

  logic             cnt_zero;
  logic             apply_cfg;
  logic             stop_req;
  logic             burst_done;
  logic [CNT_W-1:0] hi_eff;
  logic [CNT_W-1:0] lo_eff;

  assign cnt_zero  = (cnt_reg == '0);
  assign stop_req  = STOP | stop_reg;
  // New lengths only take effect at a period boundary or while idle.
  assign apply_cfg = !cfg_rdy_reg &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_HIGH) && cnt_zero));
  assign hi_eff    = apply_cfg ? pend_hi_reg : hi_len_reg;
  assign lo_eff    = apply_cfg ? pend_lo_reg : lo_len_reg;

`ifdef CLOCK_PATTERN_GEN_BURST_EN
  logic [CNT_W-1:0] edges_reg, edges_next;

  assign burst_done = (BURST_LEN != '0) && (edges_reg >= BURST_LEN);

  always_comb begin
    edges_next = edges_reg;
    if ((state_reg == ST_IDLE) && (state_next == ST_LOW)) begin
      edges_next = '0;
    end else if ((state_reg != ST_HIGH) && (state_next == ST_HIGH) && (edges_reg != '1)) begin
      edges_next = edges_reg + LEN_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edges_reg <= '0;
    else        edges_reg <= edges_next;
  end

  assign EDGES = edges_reg;
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START && !STOP) begin
          state_next = ST_LOW;
          cnt_next   = lo_eff - LEN_ONE;
        end
      end
      ST_LOW: begin
        if (stop_req) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_zero) begin
          state_next = ST_HIGH;
          cnt_next   = hi_eff - LEN_ONE;
        end else begin
          cnt_next   = cnt_reg - LEN_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (stop_req || burst_done) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            state_next = ST_LOW;
            cnt_next   = lo_eff - LEN_ONE;
          end
        end else begin
          cnt_next = cnt_reg - LEN_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    hi_len_next  = hi_eff;
    lo_len_next  = lo_eff;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    cfg_rdy_next = cfg_rdy_reg;
    if (cfg_rdy_reg) begin
      if (CFG_EN) begin
        pend_hi_next = (CFG_HI == '0) ? LEN_ONE : CFG_HI;
        pend_lo_next = (CFG_LO == '0) ? LEN_ONE : CFG_LO;
        cfg_rdy_next = 1'b0;
      end
    end else if (apply_cfg) begin
      cfg_rdy_next = 1'b1;
    end
    stop_next    = (state_next != ST_IDLE) && stop_req;
    // Idle holds its level (possibly INIT_VAL); everything else follows the phase.
    clk_val_next = (state_next == ST_HIGH) ||
                   ((state_reg == ST_IDLE) && (state_next == ST_IDLE) && clk_val_reg);
    clk_en_next  = clk_val_next ^ clk_val_reg;
    running_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_len_reg  <= LEN_ONE;
      lo_len_reg  <= LEN_ONE;
      pend_hi_reg <= LEN_ONE;
      pend_lo_reg <= LEN_ONE;
      cfg_rdy_reg <= 1'b1;
      stop_reg    <= 1'b0;
      clk_val_reg <= INIT_VAL;
      clk_en_reg  <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_len_reg  <= hi_len_next;
      lo_len_reg  <= lo_len_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      cfg_rdy_reg <= cfg_rdy_next;
      stop_reg    <= stop_next;
      clk_val_reg <= clk_val_next;
      clk_en_reg  <= clk_en_next;
      running_reg <= running_next;
    end
  end

  clock_pattern_gate_sync #(
    .INIT_GATE(INIT_GATE)
  ) u_gate_sync (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .state      (state_reg),
    .cnt_zero   (cnt_zero),
    .gate_en    (GATE_EN),
    .gate_val   (GATE_VAL),
    .gate_pend  (GATE_PEND),
    .cond_val   (COND_VAL),
    .cond_val_en(COND_VAL_EN)
  );

  assign CFG_RDY    = cfg_rdy_reg;
  assign CLK_VAL    = clk_val_reg;
  assign CLK_VAL_EN = clk_en_reg;
  assign RUNNING    = running_reg;

endmodule
